ex_stage_alu: RTL and testbench

Execute-stage arithmetic block of the 16-bit datapath. It combines three functions:
- ALU-control decode: opcode inst[15:12] plus function field inst[3:0] produce a 4-bit ALU operation.
- 16-bit ALU: produces a 32-bit result split into upper/lower halves, plus zero/negative flags.
- PC incrementer: next sequential address = PC + 2.

It sits between the register file (operands) and write-back, where the upper half targets R15 and the lower half the destination register.

---
 rtl/ex_stage_alu_pkg.sv | 39 +++
 rtl/ex_stage_alu_if.sv | 35 +++
 rtl/ex_alu_decode.sv | 32 +++
 rtl/ex_stage_alu.sv | 95 +++++++++
 tb/tb_ex_stage_alu.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ex_stage_alu_pkg.sv
// ex_stage_alu_pkg
// Shared definitions for the execute-stage ALU slice: datapath widths,
// ALU operation encodings, and the instruction opcode values the decoder
// recognises.
package ex_stage_alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int PC_INC = 2;

  // The R-type func field maps onto these codes one-to-one, so the
  // values 0..10 must stay in this order.
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_MUL = 4'h4,
    ALU_DIV = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_ROL = 4'h8,
    ALU_ROR = 4'h9,
    ALU_MOV = 4'hA,
    ALU_NOP = 4'hF
  } alu_op_e;

  localparam logic [3:0] OPC_RTYPE = 4'd0;
  localparam logic [3:0] OPC_BEQ   = 4'd4;
  localparam logic [3:0] OPC_BLT   = 4'd5;
  localparam logic [3:0] OPC_BGT   = 4'd6;
  localparam logic [3:0] OPC_ANDI  = 4'd8;
  localparam logic [3:0] OPC_ORI   = 4'd9;
  localparam logic [3:0] OPC_LW    = 4'd10;
  localparam logic [3:0] OPC_SW    = 4'd11;
  localparam logic [3:0] OPC_JMP   = 4'd12;
  localparam logic [3:0] OPC_HALT  = 4'd15;

endpackage

// File: rtl/ex_stage_alu_if.sv
// ex_stage_alu_if
// Bundles the execute-stage operand/result signals.
//   opcode, func : instruction bits [15:12] and [3:0]
//   op1, op2     : register-file read operands
//   pc_in        : current program counter
//   pc_next      : pc_in + PC_INC (combinational)
//   alu_op       : decoded ALU operation (combinational)
//   up, low      : registered upper/lower result halves
//   ze           : registered flags, [0] zero, [1] negative
// master = instruction/operand source, slave = the execute stage.
interface ex_stage_alu_if;
  import ex_stage_alu_pkg::*;

  logic [3:0]        opcode;
  logic [3:0]        func;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_next;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] up;
  logic [DATA_W-1:0] low;
  logic [1:0]        ze;

  modport master (
    output opcode, func, op1, op2, pc_in,
    input  pc_next, alu_op, up, low, ze
  );

  modport slave (
    input  opcode, func, op1, op2, pc_in,
    output pc_next, alu_op, up, low, ze
  );

endinterface

// File: rtl/ex_alu_decode.sv
// ex_alu_decode
// Combinational ALU-control decoder.
//   opcode : instruction bits [15:12]
//   func   : instruction bits [3:0], only meaningful for R-type
//   alu_op : ALU operation; anything unrecognised decodes to ALU_NOP
module ex_alu_decode
  import ex_stage_alu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] func,
  output alu_op_e    alu_op
);

  always_comb begin
    // NOTE: default assigned first so every path drives alu_op; no latch.
    alu_op = ALU_NOP;
    case (opcode)
      OPC_RTYPE: if (func <= 4'd10) alu_op = alu_op_e'(func);
      OPC_ANDI:  alu_op = ALU_AND;
      OPC_ORI:   alu_op = ALU_OR;
      OPC_LW,
      OPC_SW:    alu_op = ALU_ADD;   // address = base + offset
      OPC_BEQ,
      OPC_BLT,
      OPC_BGT:   alu_op = ALU_SUB;   // branch compare via difference
      OPC_JMP:   alu_op = ALU_MOV;
      OPC_HALT:  alu_op = ALU_NOP;
      default:   alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/ex_stage_alu.sv
// ex_stage_alu
// Execute stage: ALU-control decode, 16-bit ALU with registered 32-bit
// result (up/low) and zero/negative flags, and the PC incrementer.
//   CLOCK : system clock, rising edge
//   CLEAR : synchronous active-high clear of up/low/ze
//   bus   : ex_stage_alu_if slave (operands in, results out)
// Results for inputs present at edge N appear after edge N. NOP leaves
// the result registers untouched.
module ex_stage_alu
  import ex_stage_alu_pkg::*;
(
  input  logic            CLOCK,
  input  logic            CLEAR,
  ex_stage_alu_if.slave   bus
);

  alu_op_e                  op;
  logic [DATA_W-1:0]        res_up;
  logic [DATA_W-1:0]        res_low;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0] div_q;
  logic signed [DATA_W-1:0] div_r;
  logic [3:0]               sh;
  logic [4:0]               sh_inv;

  ex_alu_decode u_decode (
    .opcode (bus.opcode),
    .func   (bus.func),
    .alu_op (op)
  );

  assign bus.alu_op  = op;
  assign bus.pc_next = bus.pc_in + ADDR_W'(PC_INC);

  assign sh     = bus.op2[3:0];
  assign sh_inv = 5'd16 - {1'b0, sh};   // shift by 16 yields 0, so sh=0 rotates cleanly
  assign prod   = $signed(bus.op1) * $signed(bus.op2);

  // -32768 / -1 overflows a 16-bit signed quotient; its wrapped result
  // (0x8000, remainder 0) is produced explicitly rather than relying on
  // simulator/synthesis behaviour for the overflow case.
  always_comb begin
    div_q = '0;
    div_r = '0;
    if (bus.op1 == 16'h8000 && bus.op2 == 16'hFFFF) begin
      div_q = 16'sh8000;
      div_r = '0;
    end else if (bus.op2 != '0) begin
      div_q = $signed(bus.op1) / $signed(bus.op2);
      div_r = $signed(bus.op1) % $signed(bus.op2);
    end
  end

  always_comb begin
    res_up  = '0;
    res_low = '0;
    case (op)
      ALU_ADD: res_low = bus.op1 + bus.op2;
      ALU_SUB: res_low = bus.op1 - bus.op2;
      ALU_AND: res_low = bus.op1 & bus.op2;
      ALU_OR:  res_low = bus.op1 | bus.op2;
      ALU_MUL: {res_up, res_low} = prod;
      ALU_DIV: begin
        if (bus.op2 == '0) begin
          res_up  = bus.op1;
          res_low = 16'hFFFF;
        end else begin
          res_up  = div_r;
          res_low = div_q;
        end
      end
      ALU_SLL: res_low = bus.op1 << sh;
      ALU_SRL: res_low = bus.op1 >> sh;
      ALU_ROL: res_low = (bus.op1 << sh) | (bus.op1 >> sh_inv);
      ALU_ROR: res_low = (bus.op1 >> sh) | (bus.op1 << sh_inv);
      ALU_MOV: res_low = bus.op2;
      default: ;   // NOP: result unused, registers hold
    endcase
  end

  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignments for registered state; CLEAR is checked
    // first so it wins over any operation presented in the same cycle.
    if (CLEAR) begin
      bus.up  <= '0;
      bus.low <= '0;
      bus.ze  <= '0;
    end else if (op != ALU_NOP) begin
      bus.up  <= res_up;
      bus.low <= res_low;
      bus.ze  <= {res_low[DATA_W-1], (res_low == '0)};
    end
  end

endmodule

// File: tb/tb_ex_stage_alu.sv
// tb_ex_stage_alu
// Randomised + directed bench for ex_stage_alu. The driver applies one
// instruction per cycle, checks the combinational decode and PC outputs,
// and pushes the expected registered result from a behavioural model into
// a scoreboard queue; a separate monitor pops and compares after each edge.
module tb_ex_stage_alu;

  typedef struct packed {
    logic [15:0] up;
    logic [15:0] low;
    logic [1:0]  ze;
  } res_t;

  logic clk;
  logic clear;
  ex_stage_alu_if bus ();

  ex_stage_alu dut (
    .CLOCK (clk),
    .CLEAR (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  res_t sb[$];
  res_t model_state;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Decode table written straight from the instruction-set description.
  function automatic int exp_alu_op(input int opc, input int fn);
    if (opc == 0) return (fn <= 10) ? fn : 15;
    if (opc == 8) return 2;
    if (opc == 9) return 3;
    if (opc == 10 || opc == 11) return 0;
    if (opc >= 4 && opc <= 6) return 1;
    if (opc == 12) return 10;
    return 15;
  endfunction

  // Returns {up, low} as plain integer arithmetic on the operand values.
  function automatic logic [31:0] model_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb_, n, v, up_v, low_v;
    sa = int'($signed(a));
    sb_ = int'($signed(b));
    n = int'(b[3:0]);
    up_v = 0;
    low_v = 0;
    case (op)
      0:  low_v = int'(a) + int'(b);
      1:  low_v = int'(a) - int'(b);
      2:  low_v = int'(a & b);
      3:  low_v = int'(a | b);
      4:  begin v = sa * sb_; up_v = v >>> 16; low_v = v; end
      5:  begin
            if (b == 0) begin up_v = int'(a); low_v = 16'hFFFF; end
            else begin low_v = sa / sb_; up_v = sa % sb_; end
          end
      6:  low_v = int'(a) * (1 << n);
      7:  low_v = int'(a) / (1 << n);
      8:  begin v = int'(a); for (int i = 0; i < n; i++) v = ((v * 2) | (v / 32768)) & 16'hFFFF; low_v = v; end
      9:  begin v = int'(a); for (int i = 0; i < n; i++) v = ((v / 2) | ((v % 2) * 32768)) & 16'hFFFF; low_v = v; end
      10: low_v = int'(b);
      default: ;
    endcase
    return {up_v[15:0], low_v[15:0]};
  endfunction

  task automatic issue(input int opc, input int fn, input logic [15:0] a,
                       input logic [15:0] b, input logic clr, input logic [7:0] pc);
    int op;
    logic [31:0] r;
    int pc_exp;
    @(negedge clk);
    bus.opcode = 4'(opc);
    bus.func   = 4'(fn);
    bus.op1    = a;
    bus.op2    = b;
    bus.pc_in  = pc;
    clear      = clr;
    #1;
    op = exp_alu_op(opc, fn);
    pc_exp = (int'(pc) + 2) % 256;
    check($sformatf("alu_op opc=%0d fn=%0d", opc, fn), 64'(bus.alu_op), 64'(op));
    check($sformatf("pc_next pc=%h clr=%b", pc, clr), 64'(bus.pc_next), 64'(pc_exp));
    if (clr) model_state = '0;
    else if (op != 15) begin
      r = model_alu(op, a, b);
      model_state.up  = r[31:16];
      model_state.low = r[15:0];
      model_state.ze  = {r[15], r[15:0] == 16'h0};
    end
    sb.push_back(model_state);
  endtask

  // Monitor: one registered result per edge, matched in order.
  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result {up,low,ze}", 64'({bus.up, bus.low, bus.ze}), 64'(e));
      end
    end
  end

  initial begin
    logic [15:0] a, b;
    bus.opcode = '0; bus.func = '0; bus.op1 = '0; bus.op2 = '0; bus.pc_in = '0;
    clear = 1'b1;
    model_state = '0;

    issue(0, 0, 16'h0000, 16'h0000, 1'b1, 8'h00);
    // MUL activity, clear, then ADD
    issue(0, 4, 16'hFFFE, 16'h0003, 1'b0, 8'h10);
    issue(0, 4, 16'h1234, 16'h0FF1, 1'b1, 8'h12);
    issue(0, 0, 16'h0003, 16'h0004, 1'b0, 8'h14);
    // MUL sign and overflow into up
    issue(0, 4, 16'hFFFE, 16'h0003, 1'b0, 8'h16);
    issue(0, 4, 16'h0100, 16'h0100, 1'b0, 8'h18);
    // DIV signed, by zero, and the overflow corner
    issue(0, 5, 16'hFFF9, 16'h0002, 1'b0, 8'h1A);
    issue(0, 5, 16'h0005, 16'h0000, 1'b0, 8'h1C);
    issue(0, 5, 16'h8000, 16'hFFFF, 1'b0, 8'h1E);
    issue(0, 5, 16'h0007, 16'hFFFE, 1'b0, 8'h20);
    // SUB to zero, branch decode, ROR wrap, NOP hold
    issue(0, 1, 16'h1234, 16'h1234, 1'b0, 8'h22);
    issue(4, 7, 16'h0010, 16'h0020, 1'b0, 8'h24);
    issue(0, 9, 16'h0001, 16'h0001, 1'b0, 8'h26);
    issue(15, 0, 16'hAAAA, 16'h5555, 1'b0, 8'h28);
    issue(0, 13, 16'h1111, 16'h2222, 1'b0, 8'h2A);
    issue(0, 8, 16'h8001, 16'h0000, 1'b0, 8'h2C);
    issue(0, 8, 16'h8001, 16'h0004, 1'b0, 8'h2E);
    // PC wrap, with and without CLEAR
    issue(0, 10, 16'h0, 16'h7777, 1'b0, 8'h00);
    issue(0, 10, 16'h0, 16'h7777, 1'b1, 8'h7E);
    issue(0, 10, 16'h0, 16'h8000, 1'b0, 8'hFE);
    issue(0, 10, 16'h0, 16'h8000, 1'b1, 8'hFF);
    issue(0, 10, 16'h0, 16'h8000, 1'b0, 8'hFF);

    // Full opcode x func sweep with random operands
    for (int o = 0; o < 16; o++)
      for (int f = 0; f < 16; f++)
        issue(o, f, 16'($urandom), 16'($urandom), 1'b0, 8'($urandom));

    // Random stream with occasional clears and zero operands
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      issue(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), a, b,
            ($urandom_range(0, 31) == 0), 8'($urandom));
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
